// File: rtl/led_stripe_decoder.sv
// led_stripe_decoder
//   Receive side of the LED stripe one-wire protocol. The stripe line is
//   synchronised and edge-detected. Each high pulse is then classified by its
//   width as a 0 or 1 bit. Bits are assembled MSB-first into pixels. A long low
//   marks the end of a frame, and malformed pulses are flagged as errors.
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   led_stripe_in asynchronous stripe data line
//   pixel_data    last complete pixel, first received bit in MSB (holds)
//   pixel_valid   1-cycle strobe, pixel_data / pixel_index valid
//   pixel_index   0-based index of pixel_data within the frame
//   frame_end     1-cycle strobe on frame-end (long low) detection
//   pixel_count   pixels strobed in the frame just ended, valid with frame_end
//   bit_error     1-cycle strobe on malformed pulse or partial pixel
//   busy          1 while a frame is in progress (HIGH or LOW)
module led_stripe_decoder #(
  parameter int unsigned T_MIN_CYC      = 5,
  parameter int unsigned T_THRESH_CYC   = 30,
  parameter int unsigned T_MAX_HIGH_CYC = 60,
  parameter int unsigned T_RESET_CYC    = 2500,
  parameter int unsigned PIX_BITS       = 24,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned IDX_W          = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                led_stripe_in,
  output logic [PIX_BITS-1:0] pixel_data,
  output logic                pixel_valid,
  output logic [IDX_W-1:0]    pixel_index,
  output logic                frame_end,
  output logic [IDX_W-1:0]    pixel_count,
  output logic                bit_error,
  output logic                busy
);

  localparam int unsigned BCNT_W = $clog2(PIX_BITS + 1);

  localparam logic [1:0] S_RESYNC = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_HIGH   = 2'd2;
  localparam logic [1:0] S_LOW    = 2'd3;

  localparam logic [CNT_W-1:0]  MIN_C  = CNT_W'(T_MIN_CYC);
  localparam logic [CNT_W-1:0]  THR_C  = CNT_W'(T_THRESH_CYC);
  localparam logic [CNT_W-1:0]  MAXH_C = CNT_W'(T_MAX_HIGH_CYC);
  localparam logic [CNT_W-1:0]  RST_C  = CNT_W'(T_RESET_CYC);
  localparam logic [BCNT_W-1:0] LAST_B = BCNT_W'(PIX_BITS - 1);

  // Synchroniser and registered edge detector
  logic sync1_q, sync2_q, line_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      line_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= led_stripe_in;
      sync2_q <= sync1_q;
      line_q  <= sync2_q;
      // Edge strobes line up with line_q: they mark the first cycle of a new level.
      rise_q  <= sync2_q & ~line_q;
      fall_q  <= ~sync2_q & line_q;
    end
  end

  // Decoder FSM and output registers
  logic [1:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d,   cnt_inc;
  logic [BCNT_W-1:0]   bcnt_q,   bcnt_d;
  logic [PIX_BITS-1:0] shift_q,  shift_d;
  logic [IDX_W-1:0]    idx_q,    idx_d,   idx_inc;
  logic [PIX_BITS-1:0] pdata_q,  pdata_d;
  logic [IDX_W-1:0]    pidx_q,   pidx_d;
  logic [IDX_W-1:0]    pcount_q, pcount_d;
  logic                pvalid_q, pvalid_d;
  logic                fend_q,   fend_d;
  logic                berr_q,   berr_d;
  logic                err;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign idx_inc = (idx_q == '1) ? idx_q : idx_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    pdata_d  = pdata_q;
    pidx_d   = pidx_q;
    pcount_d = pcount_q;
    pvalid_d = 1'b0;
    fend_d   = 1'b0;
    berr_d   = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_RESYNC: begin
        if (line_q) begin
          cnt_d = '0;
        end else if (cnt_q == RST_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_IDLE: begin
        if (rise_q) begin
          state_d = S_HIGH;
          cnt_d   = CNT_W'(1);
          bcnt_d  = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      S_HIGH: begin
        // A high that has lasted T_MAX_HIGH_CYC is stuck even if it falls now.
        if (cnt_q == MAXH_C) begin
          err = 1'b1;
        end else if (fall_q) begin
          if (cnt_q < MIN_C) begin
            err = 1'b1;
          end else begin
            shift_d = {shift_q[PIX_BITS-2:0], (cnt_q >= THR_C)};
            state_d = S_LOW;
            cnt_d   = CNT_W'(1);
            if (bcnt_q == LAST_B) begin
              pvalid_d = 1'b1;
              pdata_d  = shift_d;
              pidx_d   = idx_q;
              idx_d    = idx_inc;
              bcnt_d   = '0;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin // S_LOW
        if (cnt_q == RST_C) begin
          fend_d   = 1'b1;
          pcount_d = idx_q;
          berr_d   = (bcnt_q != '0);
          bcnt_d   = '0;
          shift_d  = '0;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (rise_q) begin
          state_d = S_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
    if (err) begin
      berr_d  = 1'b1;
      bcnt_d  = '0;
      idx_d   = '0;
      shift_d = '0;
      state_d = S_RESYNC;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_RESYNC;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      pdata_q  <= '0;
      pidx_q   <= '0;
      pcount_q <= '0;
      pvalid_q <= 1'b0;
      fend_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      pdata_q  <= pdata_d;
      pidx_q   <= pidx_d;
      pcount_q <= pcount_d;
      pvalid_q <= pvalid_d;
      fend_q   <= fend_d;
      berr_q   <= berr_d;
    end
  end

  assign pixel_data  = pdata_q;
  assign pixel_valid = pvalid_q;
  assign pixel_index = pidx_q;
  assign frame_end   = fend_q;
  assign pixel_count = pcount_q;
  assign bit_error   = berr_q;
  assign busy        = (state_q == S_HIGH) || (state_q == S_LOW);

endmodule
